int_ctrl: RTL

- Interrupt controller sitting directly upstream of the cpu; drives the cpu's interrupt interface in place of raw `interrupciones` lines.
- Edge-detects the external request lines, latches them as pending and applies a cpu-writable mask.
- Selects the highest-priority request and presents a vector address to the cpu over a req/ack handshake.
- Tracks one in-service interrupt until the cpu signals return-from-interrupt.

---
 rtl/int_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: priority interrupt controller placed between the external
// interrupt lines (interrupciones) and the cpu.
//
// Rising edges on irq_in are latched into a pending register, qualified by a
// cpu-writable mask, and the lowest-index eligible line is offered to the cpu
// as a vector address over an irq_req/irq_ack handshake. One interrupt is
// tracked in service until the cpu signals irq_done.
//
// Optional build macro:
//   IRQ_SYNC_EN - adds a two-flop synchronizer on every irq_in bit ahead of
//                 the edge detector (edge-to-irq_req latency 2 -> 4 cycles).
//                 When undefined, irq_in must already be synchronous to clk.
//
// Reset is synchronous and active-low (reset == 0 at a rising clk edge).

module int_ctrl #(
    parameter int                 N_IRQ      = 3,
    parameter int                 VEC_W      = 10,
    parameter logic [VEC_W-1:0]   VEC_BASE   = 10'h3F0,
    parameter int                 VEC_STRIDE = 4,
    parameter logic [N_IRQ-1:0]   MASK_RST   = 3'b111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_wdata,
    input  logic              irq_ack,
    input  logic              irq_done,
    output logic              irq_req,
    output logic [VEC_W-1:0]  irq_vec,
    output logic [1:0]        irq_id,
    output logic [N_IRQ-1:0]  pending,
    output logic              in_service
);

    // ------------------------------------------------------------------
    // Handshake state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        id_q, id_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  mask_q, mask_d;
    logic [N_IRQ-1:0]  prev_q;

    logic [N_IRQ-1:0]  irq_s;      // irq_in as seen by the edge detector
    logic [N_IRQ-1:0]  rise;       // one-cycle pulse per detected rising edge
    logic [N_IRQ-1:0]  eligible;   // pending and enabled
    logic [N_IRQ-1:0]  clr;        // pending bit retired by an ack
    logic [1:0]        sel;        // lowest-index eligible line
    logic              sel_valid;
    logic [VEC_W-1:0]  sel_vec;    // vector address of sel

    // ------------------------------------------------------------------
    // Optional input synchronizer
    // ------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer; during reset both stages track irq_in so a line
    // already high when reset is released does not look like a fresh edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= irq_in;
            sync2_q <= irq_in;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    // Previous-sample register; loads the live value even in reset so a line
    // held high across reset release produces no edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge value of its inputs regardless of statement order;
        // blocking (=) here would create order-dependent simulation races.
        prev_q <= irq_s;
    end

    assign rise = irq_s & ~prev_q;

    // ------------------------------------------------------------------
    // Arbitration: lowest index wins
    // ------------------------------------------------------------------
    assign eligible  = pending_q & mask_q;
    assign sel_valid = |eligible;

    // Priority encoder; scanning downwards lets the lowest set index
    // overwrite any higher one.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // at the top; a path that leaves one unassigned infers a latch.
        sel = 2'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel = 2'(i);
            end
        end
    end

    // Vector address wraps modulo 2^VEC_W by construction of the width.
    assign sel_vec = VEC_BASE + (VEC_W'(sel) * VEC_W'(VEC_STRIDE));

    // ------------------------------------------------------------------
    // FSM next-state and handshake decode
    // ------------------------------------------------------------------
    // Next state, captured id/vector and the pending-clear strobe.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        clr     = '0;

        unique case (state_q)
            IDLE: begin
                // Selection uses the mask as it stands this cycle; a mask
                // write in the same cycle only takes effect from next edge.
                if (sel_valid) begin
                    state_d = REQ;
                    id_d    = sel;
                    vec_d   = sel_vec;
                end
            end

            REQ: begin
                // No re-arbitration: id/vec stay frozen until the cpu acks,
                // even if a higher-priority line arrives or the mask changes.
                // irq_done is ignored here, including when it coincides with ack.
                if (irq_ack) begin
                    state_d = SERVICE;
                    clr     = N_IRQ'(1) << id_q;
                end
            end

            SERVICE: begin
                if (irq_done) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending and mask next-state
    // ------------------------------------------------------------------
    // A new edge and an ack on the same line in one cycle keeps the line
    // pending: the set term is ORed in after the clear.
    always_comb begin
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // FSM, captured request, pending and mask registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            id_q      <= 2'd0;
            vec_q     <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            vec_q     <= vec_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded straight from registers, so glitch-free
    // ------------------------------------------------------------------
    assign irq_req    = (state_q == REQ);
    assign in_service = (state_q == SERVICE);
    assign irq_id     = id_q;
    assign irq_vec    = vec_q;
    assign pending    = pending_q;

endmodule
